// File: rtl/lz77_pkg.sv
// LZ77 history buffer shared definitions.
// Bank geometry helpers derived from window depth and bank count.
package lz77_pkg;

  // Bits of the address that select a bank.
  function automatic int lane_sel_w(input int lanes);
    return $clog2(lanes);
  endfunction

  // Bits of the address that select a row inside one bank.
  function automatic int row_w(input int addr_w, input int lanes);
    return addr_w - $clog2(lanes);
  endfunction

  // Largest legal backward distance; the guard band keeps reads
  // clear of the bank row being overwritten.
  function automatic int dist_max(input int addr_w, input int lanes);
    return (1 << addr_w) - lanes;
  endfunction

endpackage

// File: rtl/lz77_hist_bank.sv
// One history bank: simple dual-port RAM.
// Single write port, registered read port with no enable.
module lz77_hist_bank #(
  parameter int ROW_W  = 12,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ROW_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ROW_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ROW_W];
  logic [DATA_W-1:0] r_q;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, every cycle.
  always_ff @(posedge i_clk) begin
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lz77_history_ram.sv
// Banked LZ77 sliding-window history buffer.
// One byte appended per cycle; RD_BYTES past bytes read, 2-cycle latency.
module lz77_history_ram
  import lz77_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int LANES    = 4,
  parameter int RD_BYTES = 3,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wen,
  input  logic [DATA_W-1:0]          wbyte,
  output logic [ADDR_W-1:0]          wptr,
  output logic [ADDR_W:0]            fill,
  input  logic                       ren,
  input  logic [ADDR_W-1:0]          rdist,
  output logic                       rd_vld,
  output logic [RD_BYTES*DATA_W-1:0] rbytes,
  output logic [RD_BYTES-1:0]        rbyte_vld
);

  localparam int LSW = lane_sel_w(LANES);
  localparam int ROW_W = row_w(ADDR_W, LANES);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] DMAX =
    (ADDR_W+1)'(dist_max(ADDR_W, LANES));

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_fill;
  logic              w_flush;

  logic [ADDR_W-1:0] w_a;
  logic [LSW-1:0]    w_rot;
  logic [ROW_W-1:0]  w_base;
  logic              w_dist_ok;
  logic [RD_BYTES-1:0] w_lv;

  logic                r_s1_v;
  logic [LSW-1:0]      r_s1_rot;
  logic [RD_BYTES-1:0] r_s1_lv;
  logic [ROW_W-1:0]    r_row [LANES];

  logic                r_s2_v;
  logic [LSW-1:0]      r_s2_rot;
  logic [RD_BYTES-1:0] r_s2_lv;

  logic [LANES-1:0]  w_we;
  logic [DATA_W-1:0] w_q [LANES];

  assign w_flush = rst | clr;

  // Write pointer and saturating fill count.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (wen) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_fill != FULL) r_fill <= r_fill + 1'b1;
    end
  end

  assign wptr = r_wptr;
  assign fill = r_fill;

  // Request address split into rotation and base row, plus lane validity.
  always_comb begin
    w_a       = r_wptr - rdist;
    w_rot     = w_a[LSW-1:0];
    w_base    = w_a[ADDR_W-1:LSW];
    w_dist_ok = (rdist != '0) &&
                ({1'b0, rdist} <= DMAX) &&
                ({1'b0, rdist} <= r_fill);
    w_lv = '0;
    for (int k = 0; k < RD_BYTES; k++) begin
      w_lv[k] = w_dist_ok && (ADDR_W'(k) < rdist);
    end
  end

  // Stage 1 control: request valid and lane validity.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_s1_v  <= 1'b0;
      r_s1_lv <= '0;
    end else begin
      r_s1_v <= ren;
      if (ren) r_s1_lv <= w_lv;
    end
  end

  // Stage 1 data: rotation and per-bank row (banks below r wrap a row).
  always_ff @(posedge clk) begin
    if (ren && !w_flush) begin
      r_s1_rot <= w_rot;
      for (int b = 0; b < LANES; b++) begin
        r_row[b] <= w_base + ROW_W'(LSW'(b) < w_rot);
      end
    end
  end

  // Stage 2 control: output strobe and piped lane validity.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_s2_v  <= 1'b0;
      r_s2_lv <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2_lv <= r_s1_lv;
    end
  end

  // Stage 2 data: rotation piped alongside the bank reads.
  always_ff @(posedge clk) begin
    if (r_s1_v && !w_flush) r_s2_rot <= r_s1_rot;
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    assign w_we[b] = wen && !w_flush &&
                     (r_wptr[LSW-1:0] == LSW'(b));
    lz77_hist_bank #(
      .ROW_W  (ROW_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .i_clk   (clk),
      .i_we    (w_we[b]),
      .i_waddr (r_wptr[ADDR_W-1:LSW]),
      .i_wdata (wbyte),
      .i_raddr (r_row[b]),
      .o_rdata (w_q[b])
    );
  end

  // Rotate bank outputs so lane k carries address A+k.
  always_comb begin
    rbytes = '0;
    for (int k = 0; k < RD_BYTES; k++) begin
      rbytes[k*DATA_W +: DATA_W] = w_q[LSW'(r_s2_rot + LSW'(k))];
    end
  end

  assign rd_vld    = r_s2_v;
  assign rbyte_vld = r_s2_lv;

endmodule

// File: tb/tb_lz77_history_ram.sv
// Scoreboard bench for lz77_history_ram.
// Two configurations checked against a byte-history reference model.
module tb_lz77_history_ram;

  localparam int D0 = 1 << 14;
  localparam int L0 = 4;
  localparam int R0 = 3;
  localparam int D1 = 1 << 8;
  localparam int L1 = 8;
  localparam int R1 = 5;

  typedef struct {
    logic [39:0] b;
    logic [7:0]  v;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_err = 0;
  int   n_chk = 0;

  logic        rst0, clr0, wen0, ren0;
  logic [7:0]  wbyte0;
  logic [13:0] rdist0, wptr0;
  logic [14:0] fill0;
  logic        rd_vld0;
  logic [23:0] rb0;
  logic [2:0]  rbv0;

  logic        rst1, clr1, wen1, ren1;
  logic [7:0]  wbyte1;
  logic [7:0]  rdist1, wptr1;
  logic [8:0]  fill1;
  logic        rd_vld1;
  logic [39:0] rb1;
  logic [4:0]  rbv1;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] h0[$];
  logic [7:0] h1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lz77_history_ram #(
    .ADDR_W(14), .LANES(L0), .RD_BYTES(R0), .DATA_W(8)
  ) dut0 (
    .clk(clk), .rst(rst0), .clr(clr0), .wen(wen0), .wbyte(wbyte0),
    .wptr(wptr0), .fill(fill0), .ren(ren0), .rdist(rdist0),
    .rd_vld(rd_vld0), .rbytes(rb0), .rbyte_vld(rbv0)
  );

  lz77_history_ram #(
    .ADDR_W(8), .LANES(L1), .RD_BYTES(R1), .DATA_W(8)
  ) dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .wen(wen1), .wbyte(wbyte1),
    .wptr(wptr1), .fill(fill1), .ren(ren1), .rdist(rdist1),
    .rd_vld(rd_vld1), .rbytes(rb1), .rbyte_vld(rbv1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Reference read: window = every byte since the last clear.
  function automatic exp_t ref_read(input int n, input int depth,
                                    input int lanes, input int nrd,
                                    input int d);
    exp_t e;
    int fl;
    fl = (n > depth) ? depth : n;
    e.b = '0;
    e.v = '0;
    e.due = cyc + 2;
    for (int k = 0; k < nrd; k++)
      if (d >= 1 && d <= depth - lanes && d <= fl && k < d)
        e.v[k] = 1'b1;
    return e;
  endfunction

  task automatic step0(input logic w, input logic [7:0] b,
                       input logic r, input int d, input logic c);
    exp_t e;
    int n;
    wen0 = w; wbyte0 = b; ren0 = r; rdist0 = 14'(d); clr0 = c;
    if (c) begin
      while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
      h0.delete();
    end else begin
      if (r) begin
        n = h0.size();
        e = ref_read(n, D0, L0, R0, d);
        for (int k = 0; k < R0; k++)
          if (e.v[k]) e.b[k*8 +: 8] = h0[n - d + k];
        q0.push_back(e);
      end
      if (w) h0.push_back(b);
    end
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic w, input logic [7:0] b,
                       input logic r, input int d, input logic c);
    exp_t e;
    int n;
    wen1 = w; wbyte1 = b; ren1 = r; rdist1 = 8'(d); clr1 = c;
    if (c) begin
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
      h1.delete();
    end else begin
      if (r) begin
        n = h1.size();
        e = ref_read(n, D1, L1, R1, d);
        for (int k = 0; k < R1; k++)
          if (e.v[k]) e.b[k*8 +: 8] = h1[n - d + k];
        q1.push_back(e);
      end
      if (w) h1.push_back(b);
    end
    @(posedge clk); #1;
  endtask

  // Monitor for configuration 0.
  always @(negedge clk) begin
    exp_t e;
    logic [23:0] m;
    while (q0.size() > 0 && q0[0].due < cyc) begin
      n_chk++; n_err++;
      $display("FAIL d0_missing: no rd_vld, required due cycle %0d",
               q0[0].due);
      void'(q0.pop_front());
    end
    if (rd_vld0) begin
      if (q0.size() == 0 || q0[0].due != cyc) begin
        n_chk++; n_err++;
        $display("FAIL d0_unexpected: rd_vld=1 with no request at %0d",
                 cyc);
      end else begin
        e = q0.pop_front();
        m = '0;
        for (int k = 0; k < R0; k++) if (e.v[k]) m[k*8 +: 8] = 8'hFF;
        chk("d0_vld", 64'(rbv0), 64'(e.v[2:0]));
        chk("d0_bytes", 64'(rb0 & m), 64'(e.b[23:0] & m));
      end
    end
  end

  // Monitor for configuration 1.
  always @(negedge clk) begin
    exp_t e;
    logic [39:0] m;
    while (q1.size() > 0 && q1[0].due < cyc) begin
      n_chk++; n_err++;
      $display("FAIL d1_missing: no rd_vld, required due cycle %0d",
               q1[0].due);
      void'(q1.pop_front());
    end
    if (rd_vld1) begin
      if (q1.size() == 0 || q1[0].due != cyc) begin
        n_chk++; n_err++;
        $display("FAIL d1_unexpected: rd_vld=1 with no request at %0d",
                 cyc);
      end else begin
        e = q1.pop_front();
        m = '0;
        for (int k = 0; k < R1; k++) if (e.v[k]) m[k*8 +: 8] = 8'hFF;
        chk("d1_vld", 64'(rbv1), 64'(e.v[4:0]));
        chk("d1_bytes", 64'(rb1 & m), 64'(e.b & m));
      end
    end
  end

  task automatic run0();
    rst0 = 1'b1; clr0 = 1'b0; wen0 = 1'b0; ren0 = 1'b0;
    wbyte0 = '0; rdist0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("d0_rst_wptr", 64'(wptr0), 64'd0);
    chk("d0_rst_fill", 64'(fill0), 64'd0);
    chk("d0_rst_rdvld", 64'(rd_vld0), 64'd0);
    chk("d0_rst_rbv", 64'(rbv0), 64'd0);
    rst0 = 1'b0;
    for (int i = 0; i < 32; i++) step0(1, 8'(i), 0, 0, 0);
    chk("d0_wptr32", 64'(wptr0), 64'd32);
    chk("d0_fill32", 64'(fill0), 64'd32);
    step0(0, 0, 1, 32, 0);
    for (int i = 0; i < 4; i++) step0(1, 8'(32 + i), 1, 5 + i, 0);
    chk("d0_wptr36", 64'(wptr0), 64'd36);
    repeat (3) step0(0, 0, 0, 0, 0);
    step0(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step0(1, 8'(i), 0, 0, 0);
    step0(0, 0, 1, 2, 0);
    step0(0, 0, 1, 0, 0);
    repeat (3) step0(0, 0, 0, 0, 0);
    step0(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step0(1, 8'(i), 0, 0, 0);
    step0(0, 0, 1, 20, 0);
    repeat (3) step0(0, 0, 0, 0, 0);
    step0(0, 0, 1, 3, 0);
    step0(0, 0, 0, 0, 1);
    chk("d0_clr_wptr", 64'(wptr0), 64'd0);
    chk("d0_clr_fill", 64'(fill0), 64'd0);
    step0(0, 0, 1, 1, 0);
    repeat (3) step0(0, 0, 0, 0, 0);
    for (int i = 0; i < D0 + 10; i++) step0(1, 8'(i), 0, 0, 0);
    chk("d0_fill_sat", 64'(fill0), 64'(D0));
    chk("d0_wptr_wrap", 64'(wptr0), 64'd10);
    step0(0, 0, 1, 12, 0);
    step0(0, 0, 1, D0 - 3, 0);
    step0(0, 0, 1, D0 - L0, 0);
    repeat (3) step0(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step0(1'($urandom % 2), 8'($urandom), 1'($urandom % 2),
            ($urandom % 4 == 0) ? int'($urandom_range(0, 8))
                                : int'($urandom_range(0, D0 - 1)), 0);
    step0(0, 0, 0, 0, 0);
  endtask

  task automatic run1();
    rst1 = 1'b1; clr1 = 1'b0; wen1 = 1'b0; ren1 = 1'b0;
    wbyte1 = '0; rdist1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("d1_rst_wptr", 64'(wptr1), 64'd0);
    chk("d1_rst_fill", 64'(fill1), 64'd0);
    chk("d1_rst_rdvld", 64'(rd_vld1), 64'd0);
    rst1 = 1'b0;
    for (int i = 0; i < 20000; i++)
      step1(1'($urandom % 4 != 0), 8'($urandom), 1'($urandom % 2),
            ($urandom % 3 == 0) ? int'($urandom_range(0, 10))
                                : int'($urandom_range(0, D1 - 1)),
            1'($urandom % 1000 == 0));
    step1(0, 0, 0, 0, 0);
  endtask

  initial begin
    fork
      run0();
      run1();
    join
    repeat (5) @(posedge clk);
    #1;
    chk("d0_drain", 64'(q0.size()), 64'd0);
    chk("d1_drain", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
